uart_tx_arb: RTL
================

Name: uart_tx_arb

Overview:
Round-robin arbiter and sequencer that shares the single UART transmitter between NUM_REQ byte requesters, e.g. power-up acknowledge, telemetry and fault reporting. It selects one pending requester and loads its byte into the transmitter with a one-cycle trmt strobe. It then waits for tx_done and enforces a programmable inter-byte gap before the next grant. A watchdog recovers from a transmitter that never reports completion.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
GAP_CYC, 16, idle clocks inserted after tx_done before the next grant (0 = none)
TIMEOUT, 65535, max clocks in BUSY waiting for tx_done before abort

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  grant enable; when low no new grants, in-flight byte completes
req  input  NUM_REQ  per-requester request level; data must be held until ack
req_data  input  8*NUM_REQ  requester i byte at bits [8i+7:8i]
ack  output  NUM_REQ  one-cycle pulse to the granted requester when its byte is loaded
trmt  output  1  one-cycle load strobe to UART transmitter
tx_data  output  8  byte to transmitter, registered, stable from trmt until next grant
tx_done  input  1  transmitter completion pulse
busy  output  1  high whenever state != IDLE
tx_err  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, any time incl. mid-byte): state=IDLE, ack=0, trmt=0, tx_data=8'h00, busy=0, tx_err=0, rr pointer=0, gap and watchdog counters=0.
- States: IDLE, BUSY, GAP.
- IDLE: if en && |req in cycle t, winner = first set req bit scanning upward from ptr, wrapping mod NUM_REQ.
- Effect of a grant at edge t+1: tx_data<=req_data[winner]; trmt=1 and ack[winner]=1 for that single cycle; ptr<=(winner+1) mod NUM_REQ; state->BUSY; watchdog cleared.
- Grant latency: 1 clock from req high to trmt/ack.
- BUSY: watchdog increments every clock.
  - tx_done=1 -> GAP with gap counter loaded to GAP_CYC, or directly to IDLE if GAP_CYC==0.
  - watchdog reaching TIMEOUT-1 without tx_done -> tx_err pulse, state->IDLE.
  - tx_done and timeout in the same cycle: tx_done wins, no tx_err.
- GAP: counter decrements each clock; at 0 -> IDLE. req is ignored during GAP.
- tx_done in IDLE or GAP: ignored.
- trmt is never asserted outside the IDLE->BUSY edge. At most one ack bit is set; ack is never high unless trmt is high.
- Requester holding req after its ack is treated as a new request and competes normally under round-robin. No requester can be granted twice while another requester is continuously pending.
- en falling during BUSY/GAP: current byte and gap complete, then the block remains in IDLE until en returns.
- en low in IDLE: req is ignored and the rr pointer is unchanged.
- req bits that drop before grant are simply not serviced; no latching of req inside the block.
- Reset asserted during BUSY: trmt/ack never re-pulse for that byte, and the interrupted requester must re-request.

Test Plan:
- Reset then single req[1]=1 with byte 8'h67 -> next clock trmt=1, ack=3'b010, tx_data=8'h67, busy=1. After tx_done pulse, GAP for 16 clks, then busy=0.
- req=3'b111 held with bytes A0/A1/A2, tx_done returned 5 clks after each trmt -> grant order 0,1,2,0,... with ack pulses matching and exactly 16 idle clocks between tx_done and next trmt.
- After grant to req0, req0 kept high with req2 also high -> next grant goes to req2 (ptr=1 scan), then req0.
- en=0 with req=3'b001 for 50 clks -> no trmt, no ack. en raised -> trmt on following clock.
- tx_done withheld (TIMEOUT=20 override) -> tx_err pulse 20 clks after trmt, busy drops. tx_done asserted exactly on the timeout cycle -> no tx_err, enters GAP.
- rst_n asserted 3 clks after trmt, released with req still high -> outputs 0 during reset, ptr=0, fresh grant to lowest pending requester one clock after release; GAP_CYC=0 build -> back-to-back trmt one clock after tx_done.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter and sequencer that shares one UART transmitter between NUM_REQ byte
// requesters. It adds a programmable gap after each byte and has a watchdog for a lost tx_done.
module uart_tx_arb #(
   parameter int NUM_REQ = 3,
   parameter int GAP_CYC = 16,
   parameter int TIMEOUT = 65535
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   ack,
   output logic                 trmt,
   output logic [7:0]           tx_data,
   input  logic                 tx_done,
   output logic                 busy,
   output logic                 tx_err
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [PW-1:0]        r_ptr;
   logic [WW-1:0]        r_wd;
   logic [GW-1:0]        r_gap;
   logic [NUM_REQ-1:0]   r_ack;
   logic                 r_trmt;
   logic [7:0]           r_tx_data;
   logic                 r_tx_err;

   logic [PW-1:0]        w_win;
   logic [PW-1:0]        w_ptr_next;
   logic [7:0]           w_win_data;
   logic [NUM_REQ-1:0]   w_win_onehot;
   logic                 w_any;
   logic                 w_timeout;
   logic                 w_grant;
   logic                 w_abort;

   // First pending requester at or above the pointer, wrapping around.
   function automatic logic [PW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [PW-1:0]      p);
      int            idx;
      logic [PW-1:0] sel;
      rr_pick = p;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(p) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         sel = PW'(idx);
         if (r[sel]) rr_pick = sel;
      end
   endfunction

   assign w_any      = |req;
   assign w_win      = rr_pick(req, r_ptr);
   assign w_ptr_next = (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
   assign w_timeout  = (r_wd == WW'(TIMEOUT - 1));

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign w_win_onehot[gi] = (w_win == PW'(gi));
   end

   always_comb begin
      w_win_data = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_win == PW'(i)) w_win_data = req_data[8*i +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // tx_done takes priority over the watchdog when both land in the same cycle.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (en && w_any) w_state_next = S_BUSY;
         S_BUSY: begin
            if (tx_done)        w_state_next = (GAP_CYC == 0) ? S_IDLE : S_GAP;
            else if (w_timeout) w_state_next = S_IDLE;
         end
         S_GAP:   if (r_gap <= GW'(1)) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_grant = (r_state == S_IDLE) && en && w_any;
      w_abort = (r_state == S_BUSY) && !tx_done && w_timeout;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr     <= '0;
         r_wd      <= '0;
         r_gap     <= '0;
         r_ack     <= '0;
         r_trmt    <= 1'b0;
         r_tx_data <= 8'h00;
         r_tx_err  <= 1'b0;
      end else begin
         r_trmt   <= w_grant;
         r_ack    <= w_grant ? w_win_onehot : '0;
         r_tx_err <= w_abort;
         if (w_grant) begin
            r_tx_data <= w_win_data;
            r_ptr     <= w_ptr_next;
         end
         if (w_grant)                r_wd <= '0;
         else if (r_state == S_BUSY) r_wd <= r_wd + 1'b1;
         if (r_state == S_BUSY && tx_done)         r_gap <= GW'(GAP_CYC);
         else if (r_state == S_GAP && r_gap != '0) r_gap <= r_gap - 1'b1;
      end
   end

   assign ack     = r_ack;
   assign trmt    = r_trmt;
   assign tx_data = r_tx_data;
   assign tx_err  = r_tx_err;
   assign busy    = (r_state != S_IDLE);

endmodule
